// File: rtl/box_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : box_pkg
// Shared widths, box record and per-channel FSM state for the box tracker.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package box_pkg;

    localparam int c_BOX_CW    = 13;
    localparam int c_BOX_CNT_W = 20;

    typedef enum logic [0:0] {
        ST_EMPTY    = 1'b0,
        ST_TRACKING = 1'b1
    } box_state_t;

    // Records are sized at the default widths; narrower instances zero-extend.
    typedef struct packed {
        logic [c_BOX_CW-1:0]    top;
        logic [c_BOX_CW-1:0]    bot;
        logic [c_BOX_CW-1:0]    left;
        logic [c_BOX_CW-1:0]    right;
        logic [c_BOX_CNT_W-1:0] cnt;
    } box_t;

endpackage
`default_nettype wire

// File: rtl/multi_box_tracker_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : multi_box_tracker_if
// Pixel stream, frame sync and box readout bundle of the box tracker.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface multi_box_tracker_if #(
    parameter int NCH   = 4,
    parameter int CW    = 13,
    parameter int CNT_W = 20
);
    localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             pix_valid;
    logic [CW-1:0]    row;
    logic [CW-1:0]    col;
    logic [NCH-1:0]   hit;
    logic             v_sync;
    logic [RW-1:0]    rd_ch;
    logic [CW-1:0]    box_top;
    logic [CW-1:0]    box_bot;
    logic [CW-1:0]    box_left;
    logic [CW-1:0]    box_right;
    logic [CNT_W-1:0] box_cnt;
    logic [NCH-1:0]   box_found;
    logic             frame_done;

    modport master (
        output pix_valid, row, col, hit, v_sync, rd_ch,
        input  box_top, box_bot, box_left, box_right, box_cnt, box_found, frame_done
    );

    modport slave (
        input  pix_valid, row, col, hit, v_sync, rd_ch,
        output box_top, box_bot, box_left, box_right, box_cnt, box_found, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/box_acc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : box_acc
// One colour channel: grows a bounding box per frame and publishes it.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module box_acc
    import box_pkg::*;
#(
    parameter int          CW      = c_BOX_CW,
    parameter int          CNT_W   = c_BOX_CNT_W,
    parameter int unsigned MIN_PIX = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_valid,
    input  logic [CW-1:0] row,
    input  logic [CW-1:0] col,
    input  logic          hit,
    input  logic          frame_evt,
    output box_t          pub,
    output logic          found
);
    localparam logic [c_BOX_CNT_W-1:0] c_CNT_MAX = c_BOX_CNT_W'((64'd1 << CNT_W) - 64'd1);
    localparam logic [c_BOX_CNT_W-1:0] c_CNT_ONE = c_BOX_CNT_W'(1);

    box_state_t            r_state;
    box_t                  r_work;
    box_t                  r_pub;
    logic                  r_found;
    logic                  w_take;
    logic                  w_live;
    logic                  w_qual;
    logic [c_BOX_CW-1:0]   w_row;
    logic [c_BOX_CW-1:0]   w_col;
    box_t                  w_next;

    // w_next is the working box with this cycle's hit merged in, so a hit
    // landing on the frame event still belongs to the closing frame.
    always_comb begin
        w_take = pix_valid & hit;
        w_row  = c_BOX_CW'(row);
        w_col  = c_BOX_CW'(col);
        w_next = r_work;
        w_live = (r_state == ST_TRACKING) || w_take;
        if (w_take) begin
            if (r_state == ST_EMPTY) begin
                w_next.top   = w_row;
                w_next.bot   = w_row;
                w_next.left  = w_col;
                w_next.right = w_col;
                w_next.cnt   = c_CNT_ONE;
            end else begin
                if (w_row < r_work.top)   w_next.top   = w_row;
                if (w_row > r_work.bot)   w_next.bot   = w_row;
                if (w_col < r_work.left)  w_next.left  = w_col;
                if (w_col > r_work.right) w_next.right = w_col;
                if (r_work.cnt != c_CNT_MAX) w_next.cnt = r_work.cnt + c_CNT_ONE;
            end
        end
        w_qual = w_live && (32'(w_next.cnt) >= MIN_PIX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_work  <= '0;
            r_pub   <= '0;
            r_found <= 1'b0;
        end else if (frame_evt) begin
            r_state     <= ST_EMPTY;
            r_work      <= '0;
            r_pub.top   <= w_qual ? w_next.top   : '0;
            r_pub.bot   <= w_qual ? w_next.bot   : '0;
            r_pub.left  <= w_qual ? w_next.left  : '0;
            r_pub.right <= w_qual ? w_next.right : '0;
            r_pub.cnt   <= w_next.cnt;
            r_found     <= w_qual;
        end else if (w_take) begin
            r_state <= ST_TRACKING;
            r_work  <= w_next;
        end
    end

    assign pub   = r_pub;
    assign found = r_found;

endmodule
`default_nettype wire

// File: rtl/multi_box_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : multi_box_tracker
// NCH-channel bounding-box tracker with frame publish and channel readout.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module multi_box_tracker
    import box_pkg::*;
#(
    parameter int          NCH     = 4,
    parameter int          CW      = c_BOX_CW,
    parameter int          CNT_W   = c_BOX_CNT_W,
    parameter int unsigned MIN_PIX = 16
) (
    input  logic               clk,
    input  logic               reset,
    multi_box_tracker_if.slave bus
);
    logic           r_vs_d;
    logic           r_frame_done;
    logic           w_evt;
    box_t           w_pub [NCH];
    logic [NCH-1:0] w_found;
    box_t           w_sel;

    assign w_evt = bus.v_sync & ~r_vs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_d       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_vs_d       <= bus.v_sync;
            r_frame_done <= w_evt;
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            box_acc #(
                .CW      (CW),
                .CNT_W   (CNT_W),
                .MIN_PIX (MIN_PIX)
            ) u_acc (
                .clk       (clk),
                .reset     (reset),
                .pix_valid (bus.pix_valid),
                .row       (bus.row),
                .col       (bus.col),
                .hit       (bus.hit[i]),
                .frame_evt (w_evt),
                .pub       (w_pub[i]),
                .found     (w_found[i])
            );
        end
    endgenerate

    always_comb begin
        w_sel = '0;
        if (int'(bus.rd_ch) < NCH) w_sel = w_pub[bus.rd_ch];
    end

    assign bus.box_top    = CW'(w_sel.top);
    assign bus.box_bot    = CW'(w_sel.bot);
    assign bus.box_left   = CW'(w_sel.left);
    assign bus.box_right  = CW'(w_sel.right);
    assign bus.box_cnt    = CNT_W'(w_sel.cnt);
    assign bus.box_found  = w_found;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_multi_box_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_multi_box_tracker
// Directed bench: three tracker instances (MIN_PIX 2/16, CNT_W 4) on one stream.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_multi_box_tracker;

    logic        clk;
    logic        reset;
    logic        pix_valid;
    logic        v_sync;
    logic [12:0] row;
    logic [12:0] col;
    logic [3:0]  hit;
    logic [1:0]  rd_ch;
    int          checks   = 0;
    int          failures = 0;
    int          pulses;

    multi_box_tracker_if #(.NCH(4), .CW(13), .CNT_W(20)) bus_a ();
    multi_box_tracker_if #(.NCH(4), .CW(13), .CNT_W(20)) bus_b ();
    multi_box_tracker_if #(.NCH(4), .CW(13), .CNT_W(4))  bus_c ();

    assign bus_a.pix_valid = pix_valid;
    assign bus_a.row       = row;
    assign bus_a.col       = col;
    assign bus_a.hit       = hit;
    assign bus_a.v_sync    = v_sync;
    assign bus_a.rd_ch     = rd_ch;
    assign bus_b.pix_valid = pix_valid;
    assign bus_b.row       = row;
    assign bus_b.col       = col;
    assign bus_b.hit       = hit;
    assign bus_b.v_sync    = v_sync;
    assign bus_b.rd_ch     = rd_ch;
    assign bus_c.pix_valid = pix_valid;
    assign bus_c.row       = row;
    assign bus_c.col       = col;
    assign bus_c.hit       = hit;
    assign bus_c.v_sync    = v_sync;
    assign bus_c.rd_ch     = rd_ch;

    multi_box_tracker #(.NCH(4), .CW(13), .CNT_W(20), .MIN_PIX(2)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    multi_box_tracker #(.NCH(4), .CW(13), .CNT_W(20), .MIN_PIX(16)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));
    multi_box_tracker #(.NCH(4), .CW(13), .CNT_W(4), .MIN_PIX(2)) u_dut_c (
        .clk(clk), .reset(reset), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [3:0] m, input int r, input int c);
        pix_valid = 1'b1;
        hit       = m;
        row       = 13'(r);
        col       = 13'(c);
        tick();
        pix_valid = 1'b0;
        hit       = 4'b0000;
    endtask

    task automatic chk_box(input string tag, input int dut, input int ch,
                           input int t, input int b, input int l, input int r, input int c);
        logic [31:0] ot, ob, ol, orr, oc;
        rd_ch = 2'(ch);
        #1;
        case (dut)
            0: begin
                ot = 32'(bus_a.box_top);  ob = 32'(bus_a.box_bot);
                ol = 32'(bus_a.box_left); orr = 32'(bus_a.box_right); oc = 32'(bus_a.box_cnt);
            end
            1: begin
                ot = 32'(bus_b.box_top);  ob = 32'(bus_b.box_bot);
                ol = 32'(bus_b.box_left); orr = 32'(bus_b.box_right); oc = 32'(bus_b.box_cnt);
            end
            default: begin
                ot = 32'(bus_c.box_top);  ob = 32'(bus_c.box_bot);
                ol = 32'(bus_c.box_left); orr = 32'(bus_c.box_right); oc = 32'(bus_c.box_cnt);
            end
        endcase
        chk({tag, ".top"},   ot,  32'(t));
        chk({tag, ".bot"},   ob,  32'(b));
        chk({tag, ".left"},  ol,  32'(l));
        chk({tag, ".right"}, orr, 32'(r));
        chk({tag, ".cnt"},   oc,  32'(c));
    endtask

    initial begin
        reset = 1'b1; pix_valid = 1'b0; v_sync = 1'b0;
        row = '0; col = '0; hit = '0; rd_ch = '0;
        repeat (2) tick();
        chk("rst_fd", 32'(bus_a.frame_done), 32'd0);
        chk("rst_found", 32'(bus_a.box_found), 32'd0);
        chk_box("rst_box", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        // Three hits on channel 0, then one frame event held for five cycles
        pix(4'b0001, 10, 20);
        pix(4'b0001, 50, 5);
        pix(4'b0001, 30, 90);
        v_sync = 1'b1;
        tick();
        chk("f1_fd", 32'(bus_a.frame_done), 32'd1);
        chk("f1_a_found", 32'(bus_a.box_found), 32'h1);
        chk("f1_b_found", 32'(bus_b.box_found), 32'h0);
        chk_box("f1_a", 0, 0, 10, 50, 5, 90, 3);
        chk_box("f1_b", 1, 0, 0, 0, 0, 0, 3);
        chk_box("f1_c", 2, 0, 10, 50, 5, 90, 3);
        pulses = 0;
        repeat (4) begin
            tick();
            pulses += int'(bus_a.frame_done);
        end
        v_sync = 1'b0;
        tick();
        pulses += int'(bus_a.frame_done);
        chk("vs_hold_extra_pulses", 32'(pulses), 32'd0);
        chk_box("f1_stable", 0, 0, 10, 50, 5, 90, 3);

        // Frame with no hits
        v_sync = 1'b1;
        tick();
        chk("f2_fd", 32'(bus_a.frame_done), 32'd1);
        chk("f2_found", 32'(bus_a.box_found), 32'd0);
        for (int ch = 0; ch < 4; ch++) chk_box($sformatf("f2_ch%0d", ch), 0, ch, 0, 0, 0, 0, 0);
        v_sync = 1'b0;
        tick();

        // 20 hits on ch1, 3 on ch2
        for (int i = 0; i < 20; i++) pix(4'b0010, 100 + i, 300 - i);
        pix(4'b0100, 1, 2);
        pix(4'b0100, 3, 4);
        pix(4'b0100, 5, 6);
        v_sync = 1'b1;
        tick();
        chk("f3_b_found", 32'(bus_b.box_found), 32'h2);
        chk("f3_a_found", 32'(bus_a.box_found), 32'h6);
        chk_box("f3_b_ch1", 1, 1, 100, 119, 281, 300, 20);
        chk_box("f3_b_ch2", 1, 2, 0, 0, 0, 0, 3);
        chk_box("f3_a_ch2", 0, 2, 1, 5, 2, 6, 3);
        chk_box("f3_c_ch1_sat", 2, 1, 100, 119, 281, 300, 15);
        v_sync = 1'b0;
        tick();

        // Hit in the same cycle v_sync rises joins the closing frame
        pix(4'b0001, 40, 50);
        v_sync = 1'b1; pix_valid = 1'b1; hit = 4'b0001; row = 13'd100; col = 13'd200;
        tick();
        pix_valid = 1'b0; hit = 4'b0000;
        chk("f4_fd", 32'(bus_a.frame_done), 32'd1);
        chk_box("f4_merge", 0, 0, 40, 100, 50, 200, 2);
        v_sync = 1'b0;
        tick();
        v_sync = 1'b1;
        tick();
        chk("f5_found", 32'(bus_a.box_found), 32'd0);
        chk_box("f5_empty", 0, 0, 0, 0, 0, 0, 0);
        v_sync = 1'b0;
        tick();

        // Reset mid-frame discards the partial box
        for (int i = 0; i < 8; i++) pix(4'b1000, i + 1, i + 2);
        reset = 1'b1;
        #1;
        chk("rst2_fd", 32'(bus_a.frame_done), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        pix(4'b1000, 7, 8);
        pix(4'b1000, 9, 10);
        v_sync = 1'b1;
        tick();
        chk("f6_fd", 32'(bus_c.frame_done), 32'd1);
        chk_box("f6_c_ch3", 2, 3, 7, 9, 8, 10, 2);
        chk_box("f6_a_ch3", 0, 3, 7, 9, 8, 10, 2);
        v_sync = 1'b0;
        tick();

        // Hits without pix_valid are ignored for a whole frame
        hit = 4'b1111; row = 13'd33; col = 13'd44;
        repeat (10) tick();
        v_sync = 1'b1;
        tick();
        hit = 4'b0000;
        chk("f7_found", 32'(bus_a.box_found), 32'd0);
        for (int ch = 0; ch < 4; ch++) chk_box($sformatf("f7_ch%0d", ch), 0, ch, 0, 0, 0, 0, 0);
        v_sync = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
